// File: rtl/pipeline_ctrl_gen_pkg.sv
// Shared types and stage indices for the pipeline redirect/flush/stall controller.
package pipeline_ctrl_gen_pkg;

  typedef enum logic [0:0] {StIdle = 1'b0, StPend = 1'b1} ctrl_state_e;

  localparam int unsigned StageIf    = 0;
  localparam int unsigned StageId    = 1;
  localparam int unsigned StageExu   = 2;
  localparam int unsigned StageLsu   = 3;
  localparam int unsigned StageWb    = 4;
  localparam int unsigned StoreStage = StageExu;

  localparam int unsigned DefaultXlen = 64;

endpackage

// File: rtl/pipeline_ctrl_gen_arb.sv
// Oldest-first picker: the highest-indexed requesting stage wins and supplies its target PC.
module pipeline_ctrl_gen_arb #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned IdxW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic [NSTAGE-1:0]      req_i,
  input  logic [NSTAGE*XLEN-1:0] pc_i,
  output logic                   any_o,
  output logic [IdxW-1:0]        w_o,
  output logic [XLEN-1:0]        pc_sel_o
);

  always_comb begin
    any_o    = |req_i;
    w_o      = '0;
    pc_sel_o = '0;
    // Ascending scan so the last hit (oldest stage) overwrites younger ones.
    for (int i = 0; i < int'(NSTAGE); i++) begin
      if (req_i[i]) begin
        w_o      = IdxW'(i);
        pc_sel_o = pc_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl_gen.sv
// Redirect/flush/stall controller: holds an unaccepted redirect, flushes younger stages and
// stalls fetch from exception detection until the trap redirect retires or the watchdog fires.
module pipeline_ctrl_gen
  import pipeline_ctrl_gen_pkg::*;
#(
  parameter int unsigned XLEN      = DefaultXlen,
  parameter int unsigned NSTAGE    = 5,
  parameter int unsigned CLR_STAGE = 4,
  parameter int unsigned DRAIN_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSTAGE-1:0]      redir_req_i,
  input  logic [NSTAGE*XLEN-1:0] redir_pc_i,
  input  logic [NSTAGE-1:0]      excep_i,
  input  logic                   mtip_hold_i,
  input  logic                   fetch_ready_i,
  output logic [NSTAGE-1:0]      flush_o,
  output logic                   stall_if_o,
  output logic                   stall_store_o,
  output logic                   jump_o,
  output logic [XLEN-1:0]        jumppc_o,
  output logic                   drain_tmo_o
);

  localparam int unsigned IdxW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);

  ctrl_state_e     state_q, state_d;
  logic [IdxW-1:0] pend_idx_q, pend_idx_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            exc_pend_q, exc_pend_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;

  logic            any;
  logic [IdxW-1:0] w;
  logic [XLEN-1:0] pc_sel;
  logic            override;
  logic [IdxW-1:0] idx_eff;
  logic            accepted;
  logic            tmo_hit;
  logic            exc_set, exc_clr, exc_new_hi;

  pipeline_ctrl_gen_arb #(
    .XLEN   (XLEN),
    .NSTAGE (NSTAGE),
    .IdxW   (IdxW)
  ) u_arb (
    .req_i    (redir_req_i),
    .pc_i     (redir_pc_i),
    .any_o    (any),
    .w_o      (w),
    .pc_sel_o (pc_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_idx_q  <= '0;
      pend_pc_q   <= '0;
      exc_pend_q  <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_idx_q  <= pend_idx_d;
      pend_pc_q   <= pend_pc_d;
      exc_pend_q  <= exc_pend_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // An equal-or-older request arriving while a redirect is pending replaces it.
  assign override = (state_q == StPend) && any && (w >= pend_idx_q);
  assign idx_eff  = (state_q == StIdle || override) ? w : pend_idx_q;
  assign accepted = jump_o && fetch_ready_i;

  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_pc_d  = pend_pc_q;
    unique case (state_q)
      StIdle: begin
        if (any && !fetch_ready_i) begin
          state_d    = StPend;
          pend_idx_d = w;
          pend_pc_d  = pc_sel;
        end
      end
      StPend: begin
        if (fetch_ready_i) begin
          state_d = StIdle;
        end else if (override) begin
          pend_idx_d = w;
          pend_pc_d  = pc_sel;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    exc_new_hi = 1'b0;
    for (int j = 0; j < int'(NSTAGE); j++) begin
      if (j >= int'(CLR_STAGE) && excep_i[j]) exc_new_hi = 1'b1;
    end
    exc_set = |excep_i;
    exc_clr = accepted && (idx_eff >= IdxW'(CLR_STAGE));
    tmo_hit = exc_pend_q && (drain_cnt_q == CntW'(DRAIN_MAX));

    exc_pend_d = exc_pend_q;
    if (tmo_hit || exc_clr) exc_pend_d = 1'b0;
    // A fresh exception at or past the clearing stage belongs to a newer trap and must stick.
    if (exc_set && !(exc_clr && !exc_new_hi)) exc_pend_d = 1'b1;

    drain_cnt_d = (exc_pend_q && exc_pend_d && !tmo_hit) ? drain_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    jump_o   = 1'b0;
    jumppc_o = '0;
    flush_o  = '0;
    unique case (state_q)
      StIdle: begin
        jump_o   = any;
        jumppc_o = pc_sel;
        for (int j = 0; j < int'(NSTAGE); j++) begin
          flush_o[j] = any && (IdxW'(j) < w);
        end
      end
      StPend: begin
        jump_o   = 1'b1;
        jumppc_o = override ? pc_sel : pend_pc_q;
        for (int j = 0; j < int'(NSTAGE); j++) begin
          flush_o[j] = IdxW'(j) < idx_eff;
        end
      end
      default: ;
    endcase
    stall_if_o    = (|excep_i) || exc_pend_q || (state_q == StPend) ||
                    ((state_q == StIdle) && any && !fetch_ready_i);
    stall_store_o = mtip_hold_i && !flush_o[StoreStage];
    drain_tmo_o   = tmo_hit;
  end

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Directed self-checking bench for pipeline_ctrl_gen (NSTAGE=5, XLEN=64).
module tb_pipeline_ctrl_gen;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NSTAGE = 5;

  logic                   clk;
  logic                   rst_n;
  logic [NSTAGE-1:0]      redir_req;
  logic [NSTAGE*XLEN-1:0] redir_pc;
  logic [NSTAGE-1:0]      excep;
  logic                   mtip_hold;
  logic                   fetch_ready;
  logic [NSTAGE-1:0]      flush;
  logic                   stall_if;
  logic                   stall_store;
  logic                   jump;
  logic [XLEN-1:0]        jumppc;
  logic                   drain_tmo;

  int checks;
  int fails;

  localparam logic [XLEN-1:0] Pc1 = 64'h0000_0000_0000_1234;
  localparam logic [XLEN-1:0] Pc2 = 64'h0000_0000_8000_0100;
  localparam logic [XLEN-1:0] Pc3 = 64'h0000_0000_8000_0180;
  localparam logic [XLEN-1:0] Pc4 = 64'h0000_0000_8000_0200;

  pipeline_ctrl_gen #(
    .XLEN      (XLEN),
    .NSTAGE    (NSTAGE),
    .CLR_STAGE (4),
    .DRAIN_MAX (255)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redir_req_i   (redir_req),
    .redir_pc_i    (redir_pc),
    .excep_i       (excep),
    .mtip_hold_i   (mtip_hold),
    .fetch_ready_i (fetch_ready),
    .flush_o       (flush),
    .stall_if_o    (stall_if),
    .stall_store_o (stall_store),
    .jump_o        (jump),
    .jumppc_o      (jumppc),
    .drain_tmo_o   (drain_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redir_req = '0; excep = '0; mtip_hold = 1'b0; fetch_ready = 1'b0;
    redir_pc = '0;
    redir_pc[1*XLEN +: XLEN] = Pc1;
    redir_pc[2*XLEN +: XLEN] = Pc2;
    redir_pc[3*XLEN +: XLEN] = Pc3;
    redir_pc[4*XLEN +: XLEN] = Pc4;
    #12;
    checks++;
    if ({jump, flush, stall_if, stall_store, drain_tmo} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs: got jump=%b flush=%b stall_if=%b stall_store=%b tmo=%b, want 0",
               jump, flush, stall_if, stall_store, drain_tmo);
    end
    checks++;
    if (jumppc !== '0) begin
      fails++; $display("FAIL reset_jumppc: got %h want 0", jumppc);
    end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    redir_req = 5'b00100; fetch_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (jump !== 1'b1 || jumppc !== Pc2) begin
      fails++; $display("FAIL single_jump: got jump=%b pc=%h want 1 %h", jump, jumppc, Pc2);
    end
    checks++;
    if (flush !== 5'b00011 || stall_if !== 1'b0) begin
      fails++; $display("FAIL single_flush: got flush=%b stall_if=%b want 00011 0", flush, stall_if);
    end
    next_cycle();
    redir_req = '0;
    @(negedge clk);
    checks++;
    if (jump !== 1'b0 || flush !== 5'b0 || stall_if !== 1'b0) begin
      fails++; $display("FAIL single_idle_after: got jump=%b flush=%b stall_if=%b want 0 0 0",
                        jump, flush, stall_if);
    end
    next_cycle();
  endtask

  task automatic test_oldest_wins();
    redir_req = 5'b10100; fetch_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (jumppc !== Pc4 || flush !== 5'b01111) begin
      fails++; $display("FAIL oldest_wins: got pc=%h flush=%b want %h 01111", jumppc, flush, Pc4);
    end
    next_cycle();
    redir_req = 5'b00001;
    @(negedge clk);
    checks++;
    if (jump !== 1'b1 || flush !== 5'b00000 || jumppc !== '0) begin
      fails++; $display("FAIL stage0_redirect: got jump=%b flush=%b pc=%h want 1 00000 0",
                        jump, flush, jumppc);
    end
    next_cycle();
    redir_req = '0;
    next_cycle();
  endtask

  task automatic test_pend_override();
    redir_req = 5'b00100; fetch_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (jump !== 1'b1 || flush !== 5'b00011 || stall_if !== 1'b1) begin
      fails++; $display("FAIL pend_enter: got jump=%b flush=%b stall_if=%b want 1 00011 1",
                        jump, flush, stall_if);
    end
    next_cycle();
    redir_req = 5'b10000;
    @(negedge clk);
    checks++;
    if (jump !== 1'b1 || jumppc !== Pc4) begin
      fails++; $display("FAIL pend_override_comb: got jump=%b pc=%h want 1 %h", jump, jumppc, Pc4);
    end
    next_cycle();
    redir_req = 5'b00010;
    @(negedge clk);
    checks++;
    if (jumppc !== Pc4 || flush !== 5'b01111 || stall_if !== 1'b1) begin
      fails++; $display("FAIL pend_held: got pc=%h flush=%b stall_if=%b want %h 01111 1",
                        jumppc, flush, stall_if, Pc4);
    end
    next_cycle();
    redir_req = '0; fetch_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (jump !== 1'b1 || jumppc !== Pc4 || flush !== 5'b01111) begin
      fails++; $display("FAIL pend_accept: got jump=%b pc=%h flush=%b want 1 %h 01111",
                        jump, jumppc, flush, Pc4);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (jump !== 1'b0 || stall_if !== 1'b0 || flush !== 5'b0) begin
      fails++; $display("FAIL pend_back_idle: got jump=%b stall_if=%b flush=%b want 0 0 0",
                        jump, stall_if, flush);
    end
    next_cycle();
  endtask

  task automatic test_watchdog();
    int  n;
    bit  found;
    bit  early;
    excep = 5'b00010; redir_req = '0; fetch_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b1) begin
      fails++; $display("FAIL wd_excep_stall: got stall_if=%b want 1", stall_if);
    end
    next_cycle();
    excep = '0;
    n = 0; found = 1'b0; early = 1'b0;
    while (!found && n < 300) begin
      @(negedge clk);
      n++;
      if (drain_tmo) found = 1'b1;
      else begin
        if (stall_if !== 1'b1) early = 1'b1;
        next_cycle();
      end
    end
    checks++;
    if (!found || n != 256) begin
      fails++; $display("FAIL wd_timeout_cycle: got found=%b at cycle %0d want 1 at 256", found, n);
    end
    checks++;
    if (early) begin
      fails++; $display("FAIL wd_stall_held: got stall_if drop before timeout want held 1");
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b0 || drain_tmo !== 1'b0) begin
      fails++; $display("FAIL wd_after: got stall_if=%b tmo=%b want 0 0", stall_if, drain_tmo);
    end
    next_cycle();
  endtask

  task automatic test_exc_clear();
    bit saw_tmo;
    excep = 5'b01000; fetch_ready = 1'b1;
    next_cycle();
    excep = '0;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b1) begin
      fails++; $display("FAIL exc_pend_stall: got stall_if=%b want 1", stall_if);
    end
    next_cycle();
    next_cycle();
    redir_req = 5'b10000;
    next_cycle();
    redir_req = '0;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b0) begin
      fails++; $display("FAIL exc_cleared: got stall_if=%b want 0", stall_if);
    end
    saw_tmo = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (drain_tmo) saw_tmo = 1'b1;
    end
    checks++;
    if (saw_tmo) begin
      fails++; $display("FAIL exc_no_tmo: got drain_tmo pulse want none");
    end
    next_cycle();
    // Low exception with accepted WB redirect: clear wins.
    excep = 5'b00010; redir_req = 5'b10000;
    next_cycle();
    excep = '0; redir_req = '0;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b0) begin
      fails++; $display("FAIL clr_beats_low_set: got stall_if=%b want 0", stall_if);
    end
    next_cycle();
    // WB exception with accepted WB redirect: set wins.
    excep = 5'b10000; redir_req = 5'b10000;
    next_cycle();
    excep = '0; redir_req = '0;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b1) begin
      fails++; $display("FAIL hi_set_beats_clr: got stall_if=%b want 1", stall_if);
    end
    next_cycle();
    redir_req = 5'b10000;
    next_cycle();
    redir_req = '0;
    next_cycle();
  endtask

  task automatic test_reset_mid_pend();
    redir_req = 5'b01000; fetch_ready = 1'b0;
    next_cycle();
    redir_req = '0;
    @(negedge clk);
    checks++;
    if (jump !== 1'b1 || jumppc !== Pc3) begin
      fails++; $display("FAIL rst_pend_setup: got jump=%b pc=%h want 1 %h", jump, jumppc, Pc3);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (jump !== 1'b0 || flush !== 5'b0 || stall_if !== 1'b0) begin
      fails++; $display("FAIL rst_mid_pend: got jump=%b flush=%b stall_if=%b want 0 0 0",
                        jump, flush, stall_if);
    end
    #3 rst_n = 1'b1;
    fetch_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (jump !== 1'b0 || stall_if !== 1'b0) begin
      fails++; $display("FAIL rst_no_jump_after: got jump=%b stall_if=%b want 0 0", jump, stall_if);
    end
    next_cycle();
  endtask

  task automatic test_stall_store();
    mtip_hold = 1'b1; fetch_ready = 1'b1; redir_req = 5'b10000;
    @(negedge clk);
    checks++;
    if (flush[2] !== 1'b1 || stall_store !== 1'b0) begin
      fails++; $display("FAIL store_killed: got flush2=%b stall_store=%b want 1 0",
                        flush[2], stall_store);
    end
    next_cycle();
    redir_req = 5'b00100;
    @(negedge clk);
    checks++;
    if (stall_store !== 1'b1) begin
      fails++; $display("FAIL store_not_killed: got stall_store=%b want 1", stall_store);
    end
    next_cycle();
    redir_req = '0;
    @(negedge clk);
    checks++;
    if (stall_store !== 1'b1) begin
      fails++; $display("FAIL store_hold: got stall_store=%b want 1", stall_store);
    end
    next_cycle();
    mtip_hold = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single();
    test_oldest_wins();
    test_pend_override();
    test_watchdog();
    test_exc_clear();
    test_reset_mid_pend();
    test_stall_store();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
